multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the sequential RV32I core.
- Drives the fetch, decode-latch, LSU and register-file-write enables, and owns the architectural PC.
- Sits between the fetch unit, control unit, LSU and register file; replaces free-running enables with explicit stage sequencing.
- Provides halt/resume, a fetch timeout, illegal-opcode detection, and cycle/retired-instruction counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, max cycles in FETCH without fetch_done before the error state.
- COUNTER_WIDTH, 64, width of cycle_count and instret.

Ports:
- CLK  input  1  core clock, rising-edge.
- reset  input  1  reset.
- start  input  1  leave IDLE/HALT and begin fetching.
- halt_request  input  1  stop after the current instruction retires.
- fetch_done  input  1  fetch unit has the instruction ready.
- lsu_done  input  1  load/store access complete.
- opcode  input  7  decoded opcode of the current instruction.
- write_index  input  5  rd index.
- jump_branch_enable  input  1  taken jump/branch from the jump-branch unit.
- next_PC  input  32  sequential PC+4 from the fetch unit.
- jump_target  input  32  target from the address generator.
- enable_fetch  output  1  fetch request.
- decode_latch  output  1  capture the fetched instruction into the decode register.
- lsu_enable  output  1  LSU access strobe.
- write_enable  output  1  register-file write strobe.
- PC  output  32  architectural PC.
- state  output  3  current FSM state, for debug.
- halted  output  1  FSM is in HALT.
- fault  output  1  FSM is in ERROR (sticky).
- cycle_count  output  COUNTER_WIDTH  active-cycle counter.
- instret  output  COUNTER_WIDTH  retired-instruction counter.

Interface (already decided):
- One clock; reset is asynchronous and active-high.

Behaviour:
Reset:
- Asynchronous and active-high; takes effect immediately, including mid-instruction.
- Values on reset: state=IDLE, PC=RESET_PC, counters=0, all enables=0, halted=0, fault=0.
- An LSU access in progress is abandoned.

FSM encoding and outputs:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- Moore outputs, decoded from the state register only.

Transitions and per-state outputs:
- IDLE: all outputs 0. start → FETCH.
- FETCH: enable_fetch=1; timeout counter increments each cycle.
  - fetch_done → DECODE; timeout counter clears.
  - Counter reaches FETCH_TIMEOUT-1 with no fetch_done → ERROR.
  - fetch_done in the same cycle as the timeout → DECODE (done wins).
- DECODE: decode_latch=1 for exactly 1 cycle.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
  - Legal → EXECUTE; any other opcode → ERROR.
- EXECUTE: 1 cycle, no strobes.
  - LOAD (0000011) or STORE (0100011) → MEMORY; otherwise → WRITEBACK.
- MEMORY: lsu_enable=1, held continuously until lsu_done; then → WRITEBACK. No timeout.
- WRITEBACK: 1 cycle.
  - write_enable=1 iff opcode ∈ {LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD} and write_index≠0.
  - New PC = jump_branch_enable ? jump_target : next_PC.
  - New PC[1:0]≠0 → ERROR; PC unchanged, instret unchanged, write_enable still 0 in that cycle.
  - Otherwise PC updates and instret++.
  - Next state: opcode SYSTEM (1110011) or halt_request → HALT; else → FETCH.
- HALT: halted=1. start → FETCH, PC retained.
- ERROR: fault=1. Sticky; only reset leaves it. PC frozen at the faulting instruction.

Counters:
- cycle_count increments in every state except IDLE, HALT and ERROR.
- Both counters wrap modulo 2^COUNTER_WIDTH.

Latency:
- Non-memory instruction: 4 cycles minimum (FETCH with same-cycle fetch_done, DECODE, EXECUTE, WRITEBACK).
- Load/store: 5 cycles minimum.

Simultaneous events:
- start while already running is ignored.
- halt_request is sampled only in WRITEBACK; it must be held until halted=1.

Decomposition:
- Shared package core_pkg:
  - state enum (3-bit encodings above).
  - RV32I opcode constants.
  - a writes_rd(opcode) function, which the control unit reuses.
- One natural sub-module, fetch_watchdog: timeout counter with clear/expire, parameterised by FETCH_TIMEOUT.
- The rest is a single FSM, PC register and counters.

Test Plan:
- Reset, start, fetch_done on the first FETCH cycle, opcode 0010011, write_index=5 → state sequence 1,2,3,5,1; write_enable high only in WRITEBACK; PC 0→4; instret=1; cycle_count=4.
- LOAD with lsu_done delayed 3 cycles → lsu_enable high for exactly 3 cycles, then WRITEBACK with write_enable=1. STORE → write_enable=0, PC+4.
- JAL with jump_branch_enable=1, jump_target=0x100 → PC=0x100. jump_target=0x102 → fault=1, PC unchanged, instret unchanged.
- fetch_done held low → ERROR entered after exactly 16 FETCH cycles; opcode 0000000 in DECODE → ERROR; both stay in ERROR until reset.
- halt_request during EXECUTE → instruction retires, halted=1, cycle_count frozen; start → resumes at the next PC. SYSTEM opcode → HALT.
- reset asserted mid-MEMORY → lsu_enable drops in the same cycle, state=0, PC=RESET_PC, counters=0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg
//   Shared definitions for the sequential RV32I core: the sequencer state
//   encoding, the RV32I major opcodes, and opcode classification helpers
//   that the sequencer and the control unit both use.
package core_pkg;

  // The numeric encodings are visible on the debug 'state' port, so they
  // are fixed and must not be renumbered.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // True for instruction classes that produce a value for rd.
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_LOAD: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

  // True for every RV32I base major opcode.
  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
        is_legal_opcode = 1'b1;
      default:
        is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog
//   Counts consecutive cycles spent waiting for the fetch unit and flags
//   expiry on the FETCH_TIMEOUT-th waiting cycle.
// Ports:
//   clk     in   core clock, rising edge
//   reset   in   asynchronous active-high reset
//   active  in   sequencer is in FETCH this cycle
//   done    in   fetch unit completed this cycle (clears the count)
//   expired out  this is the last allowed FETCH cycle (combinational)
module fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic done,
  output logic expired
);

  localparam int CW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(FETCH_TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // The count is zero on the first FETCH cycle, so reaching LIMIT means
  // FETCH_TIMEOUT cycles have been spent without fetch_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (active && !done) begin
      count_reg <= count_reg + 1'b1;
    end else begin
      count_reg <= '0;
    end
  end

  assign expired = active && (count_reg == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the sequential RV32I core. Sequences
//   FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK, owns the
//   architectural PC and keeps cycle / retired-instruction counters.
// Ports:
//   CLK, reset            clock (rising edge), async active-high reset
//   start                 leave IDLE/HALT and begin fetching
//   halt_request          stop after the current instruction retires
//   fetch_done, lsu_done  completion handshakes from fetch unit / LSU
//   opcode, write_index   current instruction's opcode and rd
//   jump_branch_enable    taken jump/branch; selects jump_target
//   next_PC, jump_target  candidate next PCs
//   enable_fetch, decode_latch, lsu_enable, write_enable  stage strobes
//   PC                    architectural PC
//   state, halted, fault  debug/status
//   cycle_count, instret  performance counters
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          COUNTER_WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     halt_request,
  input  logic                     fetch_done,
  input  logic                     lsu_done,
  input  logic [6:0]               opcode,
  input  logic [4:0]               write_index,
  input  logic                     jump_branch_enable,
  input  logic [31:0]              next_PC,
  input  logic [31:0]              jump_target,
  output logic                     enable_fetch,
  output logic                     decode_latch,
  output logic                     lsu_enable,
  output logic                     write_enable,
  output logic [31:0]              PC,
  output logic [2:0]               state,
  output logic                     halted,
  output logic                     fault,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] instret
);

  state_t                   state_reg, state_next;
  logic [31:0]              pc_reg;
  logic [COUNTER_WIDTH-1:0] cycle_count_reg;
  logic [COUNTER_WIDTH-1:0] instret_reg;
  logic                     enable_fetch_reg, decode_latch_reg, lsu_enable_reg;
  logic                     halted_reg, fault_reg;

  logic                     fetch_expired;
  logic [31:0]              pc_candidate;
  logic                     pc_misaligned;
  logic                     retire;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_watchdog (
    .clk     (CLK),
    .reset   (reset),
    .active  (state_reg == ST_FETCH),
    .done    (fetch_done),
    .expired (fetch_expired)
  );

  assign pc_candidate  = jump_branch_enable ? jump_target : next_PC;
  assign pc_misaligned = |pc_candidate[1:0];
  // An instruction retires only in a WRITEBACK that lands on an aligned PC.
  assign retire        = (state_reg == ST_WRITEBACK) && !pc_misaligned;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        // fetch_done takes priority over a same-cycle timeout.
        if (fetch_done)         state_next = ST_DECODE;
        else if (fetch_expired) state_next = ST_ERROR;
      end
      ST_DECODE:    state_next = is_legal_opcode(opcode) ? ST_EXECUTE : ST_ERROR;
      ST_EXECUTE:   state_next = (opcode == OPC_LOAD || opcode == OPC_STORE)
                                 ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY:    if (lsu_done) state_next = ST_WRITEBACK;
      ST_WRITEBACK: begin
        if (pc_misaligned)                              state_next = ST_ERROR;
        else if (opcode == OPC_SYSTEM || halt_request)  state_next = ST_HALT;
        else                                            state_next = ST_FETCH;
      end
      ST_HALT:      if (start) state_next = ST_FETCH;
      ST_ERROR:     state_next = ST_ERROR;
      default:      state_next = ST_ERROR;
    endcase
  end

  // State, PC, counters and the pure state-decoded strobes. The strobes are
  // registered from state_next so they line up with state_reg exactly.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      pc_reg           <= RESET_PC;
      cycle_count_reg  <= '0;
      instret_reg      <= '0;
      enable_fetch_reg <= 1'b0;
      decode_latch_reg <= 1'b0;
      lsu_enable_reg   <= 1'b0;
      halted_reg       <= 1'b0;
      fault_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      enable_fetch_reg <= (state_next == ST_FETCH);
      decode_latch_reg <= (state_next == ST_DECODE);
      lsu_enable_reg   <= (state_next == ST_MEMORY);
      halted_reg       <= (state_next == ST_HALT);
      fault_reg        <= (state_next == ST_ERROR);

      if (state_reg != ST_IDLE && state_reg != ST_HALT && state_reg != ST_ERROR)
        cycle_count_reg <= cycle_count_reg + COUNTER_WIDTH'(1);

      if (retire) begin
        pc_reg      <= pc_candidate;
        instret_reg <= instret_reg + COUNTER_WIDTH'(1);
      end
    end
  end

  // The write strobe is qualified in the WRITEBACK cycle itself so that a
  // misaligned target suppresses the register write of the faulting op.
  assign write_enable = (state_reg == ST_WRITEBACK) && writes_rd(opcode) &&
                        (write_index != 5'd0) && !pc_misaligned;

  assign enable_fetch = enable_fetch_reg;
  assign decode_latch = decode_latch_reg;
  assign lsu_enable   = lsu_enable_reg;
  assign halted       = halted_reg;
  assign fault        = fault_reg;
  assign state        = state_reg;
  assign PC           = pc_reg;
  assign cycle_count  = cycle_count_reg;
  assign instret      = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start, halt_request, fetch_done, lsu_done;
  logic [6:0]  opcode;
  logic [4:0]  write_index;
  logic        jump_branch_enable;
  logic [31:0] next_PC, jump_target;
  logic        enable_fetch, decode_latch, lsu_enable, write_enable;
  logic [31:0] PC;
  logic [2:0]  state;
  logic        halted, fault;
  logic [63:0] cycle_count, instret;

  int pass_count  = 0;
  int check_count = 0;

  multicycle_sequencer dut (
    .CLK                (CLK),
    .reset              (reset),
    .start              (start),
    .halt_request       (halt_request),
    .fetch_done         (fetch_done),
    .lsu_done           (lsu_done),
    .opcode             (opcode),
    .write_index        (write_index),
    .jump_branch_enable (jump_branch_enable),
    .next_PC            (next_PC),
    .jump_target        (jump_target),
    .enable_fetch       (enable_fetch),
    .decode_latch       (decode_latch),
    .lsu_enable         (lsu_enable),
    .write_enable       (write_enable),
    .PC                 (PC),
    .state              (state),
    .halted             (halted),
    .fault              (fault),
    .cycle_count        (cycle_count),
    .instret            (instret)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
      $display("check %-24s got=0x%0h exp=0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-24s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0; halt_request = 0; fetch_done = 0; lsu_done = 0;
    opcode = 7'd0; write_index = 5'd0; jump_branch_enable = 0;
    next_PC = 32'd0; jump_target = 32'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_insn(input logic [6:0] opc, input logic [4:0] rd,
                          input logic jbe, input logic [31:0] npc, input logic [31:0] tgt);
    opcode = opc; write_index = rd; jump_branch_enable = jbe;
    next_PC = npc; jump_target = tgt;
  endtask

  initial begin
    int n;

    // ---- reset state ----
    do_reset();
    check("rst_state", state, 3'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_cycles", cycle_count, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_strobes", {enable_fetch, decode_latch, lsu_enable, write_enable}, 4'b0000);
    check("rst_status", {halted, fault}, 2'b00);

    // ---- OP-IMM, rd=5, fetch_done on first FETCH cycle ----
    set_insn(7'b0010011, 5'd5, 1'b0, 32'd4, 32'd0);
    fetch_done = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    check("alu_st_fetch", state, 3'd1);
    check("alu_en_fetch", enable_fetch, 1'b1);
    step();
    check("alu_st_decode", state, 3'd2);
    check("alu_dec_latch", decode_latch, 1'b1);
    step();
    check("alu_st_exec", state, 3'd3);
    check("alu_we_exec", write_enable, 1'b0);
    step();
    check("alu_st_wb", state, 3'd5);
    check("alu_we_wb", write_enable, 1'b1);
    step();
    check("alu_st_fetch2", state, 3'd1);
    check("alu_pc", PC, 32'd4);
    check("alu_instret", instret, 64'd1);
    check("alu_cycles", cycle_count, 64'd4);

    // ---- LOAD with lsu_done after 3 MEMORY cycles ----
    set_insn(7'b0000011, 5'd3, 1'b0, 32'd8, 32'd0);
    step(); step(); step();
    check("ld_st_mem", state, 3'd4);
    n = 0;
    for (int i = 0; i < 20 && state == 3'd4; i++) begin
      if (lsu_enable) n++;
      if (n == 3) lsu_done = 1'b1;
      step();
    end
    lsu_done = 1'b0;
    check("ld_lsu_cycles", n, 3);
    check("ld_st_wb", state, 3'd5);
    check("ld_lsu_off", lsu_enable, 1'b0);
    check("ld_we_wb", write_enable, 1'b1);
    step();
    check("ld_pc", PC, 32'd8);
    check("ld_instret", instret, 64'd2);
    check("ld_cycles", cycle_count, 64'd11);

    // ---- STORE: no register write ----
    set_insn(7'b0100011, 5'd7, 1'b0, 32'd12, 32'd0);
    lsu_done = 1'b1;
    step(); step(); step(); step();
    check("st_st_wb", state, 3'd5);
    check("st_we_wb", write_enable, 1'b0);
    step();
    lsu_done = 1'b0;
    check("st_pc", PC, 32'd12);
    check("st_instret", instret, 64'd3);

    // ---- JAL taken to 0x100 ----
    set_insn(7'b1101111, 5'd1, 1'b1, 32'd16, 32'h100);
    step(); step(); step();
    check("jal_we_wb", write_enable, 1'b1);
    step();
    check("jal_pc", PC, 32'h100);
    check("jal_instret", instret, 64'd4);

    // ---- JAL to misaligned 0x102 -> ERROR ----
    set_insn(7'b1101111, 5'd1, 1'b1, 32'h104, 32'h102);
    step(); step(); step();
    check("jalm_st_wb", state, 3'd5);
    check("jalm_we_wb", write_enable, 1'b0);
    step();
    check("jalm_state", state, 3'd7);
    check("jalm_fault", fault, 1'b1);
    check("jalm_pc", PC, 32'h100);
    check("jalm_instret", instret, 64'd4);
    n = int'(cycle_count);
    start = 1'b1;
    step(); step();
    start = 1'b0;
    check("jalm_sticky", state, 3'd7);
    check("jalm_cyc_frozen", cycle_count, 64'(n));

    // ---- fetch timeout ----
    do_reset();
    start = 1'b1;
    step(); start = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && state == 3'd1; i++) begin
      n++;
      step();
    end
    check("to_fetch_cycles", n, 16);
    check("to_state", state, 3'd7);
    check("to_fault", fault, 1'b1);
    check("to_no_fetch_en", enable_fetch, 1'b0);

    // ---- illegal opcode ----
    do_reset();
    set_insn(7'b0000000, 5'd1, 1'b0, 32'd4, 32'd0);
    fetch_done = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    step();
    check("ill_st_decode", state, 3'd2);
    step();
    check("ill_state", state, 3'd7);
    start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    check("ill_sticky", state, 3'd7);
    check("ill_pc", PC, 32'h0);

    // ---- halt_request raised in EXECUTE; rd=x0 never written ----
    do_reset();
    set_insn(7'b0010011, 5'd0, 1'b0, 32'd4, 32'd0);
    fetch_done = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    check("hlt_st_exec", state, 3'd3);
    halt_request = 1'b1;
    step();
    check("hlt_we_x0", write_enable, 1'b0);
    step();
    check("hlt_state", state, 3'd6);
    check("hlt_halted", halted, 1'b1);
    check("hlt_pc", PC, 32'd4);
    check("hlt_instret", instret, 64'd1);
    step(); step();
    check("hlt_cyc_frozen", cycle_count, 64'd4);
    halt_request = 1'b0;
    set_insn(7'b1110011, 5'd0, 1'b0, 32'd8, 32'd0);
    start = 1'b1;
    step(); start = 1'b0;
    check("res_state", state, 3'd1);
    check("res_pc", PC, 32'd4);
    check("res_halted", halted, 1'b0);
    step(); step(); step(); step();
    check("sys_state", state, 3'd6);
    check("sys_pc", PC, 32'd8);
    check("sys_instret", instret, 64'd2);

    // ---- asynchronous reset mid-MEMORY ----
    do_reset();
    set_insn(7'b0000011, 5'd2, 1'b0, 32'd4, 32'd0);
    fetch_done = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    check("arst_st_mem", state, 3'd4);
    check("arst_lsu_on", lsu_enable, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_lsu_off", lsu_enable, 1'b0);
    check("arst_state", state, 3'd0);
    check("arst_pc", PC, 32'h0);
    check("arst_cycles", cycle_count, 64'd0);
    check("arst_instret", instret, 64'd0);
    step();
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
